// File: rtl/mem_slot_sched_if.sv
// Shared-memory slot scheduler bus bundle.
// Requester ports, memory port, phase and clock enables.
interface mem_slot_sched_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic [2:0]    PHASE;
  logic          CE_12M;
  logic          CE_6M;
  logic          CE_3M;
  logic          V_REQ;
  logic [AW-1:0] V_ADDR;
  logic          V_ACK;
  logic          C_REQ;
  logic [AW-1:0] C_ADDR;
  logic          C_WE;
  logic [DW-1:0] C_WDATA;
  logic          C_ACK;
  logic          Z_REQ;
  logic [AW-1:0] Z_ADDR;
  logic          Z_WE;
  logic [DW-1:0] Z_WDATA;
  logic          Z_ACK;
  logic [DW-1:0] RDATA;
  logic          MEM_CMD;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  modport slave (
    output PHASE, CE_12M, CE_6M, CE_3M,
    input  V_REQ, V_ADDR,
    output V_ACK,
    input  C_REQ, C_ADDR, C_WE, C_WDATA,
    output C_ACK,
    input  Z_REQ, Z_ADDR, Z_WE, Z_WDATA,
    output Z_ACK, RDATA,
    output MEM_CMD, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA
  );

  modport master (
    input  PHASE, CE_12M, CE_6M, CE_3M,
    output V_REQ, V_ADDR,
    input  V_ACK,
    output C_REQ, C_ADDR, C_WE, C_WDATA,
    input  C_ACK,
    output Z_REQ, Z_ADDR, Z_WE, Z_WDATA,
    input  Z_ACK, RDATA,
    input  MEM_CMD, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/mem_slot_sched.sv
// 8-phase slot scheduler: 12/6/3 MHz enables and a
// shared memory port for VID, CPU and Z80.
module mem_slot_sched #(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input logic CLK_24M,
  input logic nRESETP,
  mem_slot_sched_if.slave bus
);
  // one-hot requester bit positions
  localparam int V = 0;
  localparam int C = 1;
  localparam int Z = 2;

  logic [2:0]    phase;
  logic [2:0]    busy;
  logic [2:0]    ack;
  logic [2:0]    ack_d;
  logic [2:0]    cmd_own;
  logic [2:0]    pipe [RD_LAT];
  logic          rr_z;
  logic [2:0]    elig;
  logic [2:0]    own;
  logic [2:0]    gnt;
  logic          free;
  logic          rr_flip;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign bus.PHASE  = phase;
  assign bus.CE_12M = phase[0];
  assign bus.CE_6M  = &phase[1:0];
  assign bus.CE_3M  = &phase;

  assign elig = {bus.Z_REQ, bus.C_REQ, bus.V_REQ} & ~busy;
  assign free = phase[0] & ~(&phase);

  assign ack       = pipe[RD_LAT-1];
  assign bus.V_ACK = ack[V];
  assign bus.C_ACK = ack[C];
  assign bus.Z_ACK = ack[Z];
  assign bus.RDATA = (|ack) ? bus.MEM_RDATA : '0;

  // Slot owner, then VID fallback, then CPU/Z80 round-robin
  always_comb begin
    own = '0;
    case (phase)
      3'd0, 3'd4: own[V] = 1'b1;
      3'd2, 3'd6: own[C] = 1'b1;
      3'd7:       own[Z] = 1'b1;
      default:    own = '0;
    endcase
    gnt = '0;
    if (|(own & elig))
      gnt = own;
    else if (elig[V])
      gnt[V] = 1'b1;
    else if (elig[C] && (!rr_z || !elig[Z]))
      gnt[C] = 1'b1;
    else if (elig[Z])
      gnt[Z] = 1'b1;
    rr_flip = free & (gnt[C] | gnt[Z]);
  end

  // Command mux for the granted requester
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt[V]: begin
        sel_addr = bus.V_ADDR;
      end
      gnt[C]: begin
        sel_we    = bus.C_WE;
        sel_addr  = bus.C_ADDR;
        sel_wdata = bus.C_WDATA;
      end
      gnt[Z]: begin
        sel_we    = bus.Z_WE;
        sel_addr  = bus.Z_ADDR;
        sel_wdata = bus.Z_WDATA;
      end
      default: begin
        sel_we = 1'b0;
      end
    endcase
  end

  // Phase, memory command, owner pipeline and busy flags
  always_ff @(posedge CLK_24M or negedge nRESETP) begin
    if (!nRESETP) begin
      phase         <= 3'd4;
      bus.MEM_CMD   <= 1'b0;
      bus.MEM_WE    <= 1'b0;
      bus.MEM_ADDR  <= '0;
      bus.MEM_WDATA <= '0;
      cmd_own       <= '0;
      ack_d         <= '0;
      busy          <= '0;
      rr_z          <= 1'b0;
      for (int i = 0; i < RD_LAT; i++)
        pipe[i] <= '0;
    end else begin
      phase       <= phase + 3'd1;
      bus.MEM_CMD <= |gnt;
      bus.MEM_WE  <= sel_we;
      if (|gnt) begin
        bus.MEM_ADDR  <= sel_addr;
        bus.MEM_WDATA <= sel_wdata;
      end
      cmd_own <= gnt;
      pipe[0] <= cmd_own;
      for (int i = 1; i < RD_LAT; i++)
        pipe[i] <= pipe[i-1];
      ack_d <= ack;
      busy  <= (busy | gnt) & ~ack_d;
      rr_z  <= rr_z ^ rr_flip;
    end
  end
endmodule

// File: tb/tb_mem_slot_sched.sv
// Directed bench for mem_slot_sched: phase/enables,
// arbitration, round-robin, writes and reset abort.
module tb_mem_slot_sched;
  logic       clk;
  logic       rst_n;
  logic [2:0] exp_ph;
  int         n_chk;
  int         n_fail;

  mem_slot_sched_if #(.AW(24), .DW(16)) bus ();

  mem_slot_sched #(
    .AW(24), .DW(16), .RD_LAT(2)
  ) dut (
    .CLK_24M(clk),
    .nRESETP(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    exp_ph = exp_ph + 3'd1;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    do step(); while (exp_ph != p);
    chk("phase_sync", 32'(bus.PHASE), 32'(p));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    exp_ph = 3'd4;
    bus.V_REQ = 0; bus.V_ADDR = '0;
    bus.C_REQ = 0; bus.C_ADDR = '0;
    bus.C_WE = 0;  bus.C_WDATA = '0;
    bus.Z_REQ = 0; bus.Z_ADDR = '0;
    bus.Z_WE = 0;  bus.Z_WDATA = '0;
    bus.MEM_RDATA = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    exp_ph = 3'd4;

    // reset state
    chk("rst_phase", 32'(bus.PHASE), 32'd4);
    chk("rst_ce12", 32'(bus.CE_12M), 32'd0);
    chk("rst_ce6", 32'(bus.CE_6M), 32'd0);
    chk("rst_ce3", 32'(bus.CE_3M), 32'd0);
    chk("rst_cmd", 32'(bus.MEM_CMD), 32'd0);
    chk("rst_we", 32'(bus.MEM_WE), 32'd0);
    chk("rst_addr", 32'(bus.MEM_ADDR), 32'd0);
    chk("rst_wdata", 32'(bus.MEM_WDATA), 32'd0);
    chk("rst_acks",
        32'({bus.V_ACK, bus.C_ACK, bus.Z_ACK}), 32'd0);
    rst_n = 1'b1;

    // free-running phase and enables, idle bus
    for (int i = 0; i < 8; i++) begin
      step();
      chk("run_phase", 32'(bus.PHASE), 32'(exp_ph));
      chk("run_ce12", 32'(bus.CE_12M),
          32'(exp_ph[0]));
      chk("run_ce6", 32'(bus.CE_6M),
          32'(exp_ph == 3 || exp_ph == 7));
      chk("run_ce3", 32'(bus.CE_3M),
          32'(exp_ph == 7));
      chk("run_idle_cmd", 32'(bus.MEM_CMD), 32'd0);
    end

    // CPU read on its own slot
    wait_phase(3'd2);
    bus.C_REQ  = 1;
    bus.C_ADDR = 24'h000100;
    step();
    chk("c_rd_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("c_rd_addr", 32'(bus.MEM_ADDR), 32'h100);
    chk("c_rd_we", 32'(bus.MEM_WE), 32'd0);
    step();
    chk("c_rd_noack", 32'(bus.C_ACK), 32'd0);
    chk("c_rd_busy", 32'(bus.MEM_CMD), 32'd0);
    step();
    chk("c_rd_ack", 32'(bus.C_ACK), 32'd1);
    chk("c_rd_data", 32'(bus.RDATA), 32'hBEEF);
    chk("c_rd_vz", 32'({bus.V_ACK, bus.Z_ACK}), 32'd0);
    chk("c_rd_noreiss", 32'(bus.MEM_CMD), 32'd0);
    bus.C_REQ = 0;
    step();
    chk("c_rd_ack1", 32'(bus.C_ACK), 32'd0);
    chk("c_rd_idle", 32'(bus.MEM_CMD), 32'd0);

    // VID beats CPU on a free slot
    wait_phase(3'd1);
    bus.V_REQ  = 1;
    bus.V_ADDR = 24'h0000A0;
    bus.C_REQ  = 1;
    bus.C_ADDR = 24'h000200;
    bus.MEM_RDATA = 16'h5A5A;
    step();
    chk("vc_v_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("vc_v_addr", 32'(bus.MEM_ADDR), 32'hA0);
    step();
    chk("vc_c_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("vc_c_addr", 32'(bus.MEM_ADDR), 32'h200);
    step();
    chk("vc_v_ack", 32'(bus.V_ACK), 32'd1);
    chk("vc_v_data", 32'(bus.RDATA), 32'h5A5A);
    chk("vc_none", 32'(bus.MEM_CMD), 32'd0);
    bus.V_REQ = 0;
    step();
    chk("vc_c_ack", 32'(bus.C_ACK), 32'd1);
    chk("vc_v_ack1", 32'(bus.V_ACK), 32'd0);
    bus.C_REQ = 0;
    step();
    chk("vc_quiet", 32'(bus.C_ACK), 32'd0);

    // CPU and Z80 held continuously
    wait_phase(3'd7);
    bus.C_REQ  = 1;
    bus.C_ADDR = 24'h000300;
    bus.Z_REQ  = 1;
    bus.Z_ADDR = 24'h000400;
    for (int i = 1; i <= 22; i++) begin
      logic cz, cc;
      step();
      cz = (i % 5 == 1);
      cc = (i % 5 == 2);
      chk("cz_cmd", 32'(bus.MEM_CMD), 32'(cz | cc));
      if (cz)
        chk("cz_z_addr", 32'(bus.MEM_ADDR), 32'h400);
      if (cc)
        chk("cz_c_addr", 32'(bus.MEM_ADDR), 32'h300);
      chk("cz_z_ack", 32'(bus.Z_ACK),
          32'(i % 5 == 3));
      chk("cz_c_ack", 32'(bus.C_ACK),
          32'(i % 5 == 4));
      chk("cz_v_ack", 32'(bus.V_ACK), 32'd0);
    end
    bus.C_REQ = 0;
    bus.Z_REQ = 0;
    repeat (6) step();

    // reset during an in-flight CPU access
    wait_phase(3'd6);
    bus.C_REQ  = 1;
    bus.C_ADDR = 24'h000500;
    step();
    chk("ra_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("ra_addr", 32'(bus.MEM_ADDR), 32'h500);
    step();
    rst_n = 1'b0;
    bus.C_REQ = 0;
    #1;
    chk("ra_phase", 32'(bus.PHASE), 32'd4);
    chk("ra_addr0", 32'(bus.MEM_ADDR), 32'd0);
    chk("ra_cmd0", 32'(bus.MEM_CMD), 32'd0);
    chk("ra_ack0", 32'(bus.C_ACK), 32'd0);
    chk("ra_ce12", 32'(bus.CE_12M), 32'd0);
    @(negedge clk);
    @(negedge clk);
    exp_ph = 3'd4;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ra_no_ack", 32'(bus.C_ACK), 32'd0);
      chk("ra_no_cmd", 32'(bus.MEM_CMD), 32'd0);
    end

    // round-robin starts at CPU, then Z80 write
    wait_phase(3'd5);
    bus.C_REQ   = 1;
    bus.C_ADDR  = 24'h000600;
    bus.Z_REQ   = 1;
    bus.Z_ADDR  = 24'h000700;
    bus.Z_WE    = 1;
    bus.Z_WDATA = 16'h1234;
    bus.MEM_RDATA = 16'hC0DE;
    step();
    chk("rr_cpu_first", 32'(bus.MEM_ADDR), 32'h600);
    chk("rr_cpu_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("rr_cpu_we", 32'(bus.MEM_WE), 32'd0);
    bus.Z_REQ = 0;
    step();
    chk("rr_gap", 32'(bus.MEM_CMD), 32'd0);
    step();
    chk("rr_c_ack", 32'(bus.C_ACK), 32'd1);
    bus.C_REQ = 0;
    wait_phase(3'd3);
    bus.C_REQ = 1;
    bus.Z_REQ = 1;
    step();
    chk("rr_z_turn", 32'(bus.MEM_ADDR), 32'h700);
    chk("zw_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("zw_we", 32'(bus.MEM_WE), 32'd1);
    chk("zw_wdata", 32'(bus.MEM_WDATA), 32'h1234);
    step();
    chk("rr_c_next", 32'(bus.MEM_ADDR), 32'h600);
    chk("rr_c_cmd", 32'(bus.MEM_CMD), 32'd1);
    chk("rr_c_we", 32'(bus.MEM_WE), 32'd0);
    step();
    chk("zw_ack", 32'(bus.Z_ACK), 32'd1);
    chk("zw_c_noack", 32'(bus.C_ACK), 32'd0);
    bus.Z_REQ = 0;
    step();
    chk("rr_c_ack2", 32'(bus.C_ACK), 32'd1);
    chk("rr_c_data", 32'(bus.RDATA), 32'hC0DE);
    chk("zw_ack_once", 32'(bus.Z_ACK), 32'd0);
    bus.C_REQ = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_slot_sched.md
# mem_slot_sched

Time-slot scheduler that divides CLK_24M into an 8-phase frame, produces the 12/6/3 MHz clock enables for the rest of the design, and shares one memory port between the video fetcher (VID), the 68k (CPU) and the Z80 (Z80). It sits beside the clock generator. Every shared-memory access in the system is issued here on a fixed phase, so bus ownership stays cycle-deterministic with respect to the video clocks.

## Interface
Parameters:
- AW, 24, address width
- DW, 16, data width
- RD_LAT, 2, cycles from MEM_CMD high to MEM_RDATA valid (range 1..4)

Ports:
- CLK_24M  in  1  system clock; all logic rising-edge
- nRESETP  in  1  reset, asynchronous, active-low
- PHASE  out  3  frame phase counter
- CE_12M, CE_6M, CE_3M  out  1 each  single-cycle clock enables
- V_REQ  in  1  VID request (read only)
- V_ADDR  in  AW  VID address
- V_ACK  out  1  VID completion
- C_REQ, Z_REQ  in  1 each  CPU and Z80 requests
- C_ADDR, Z_ADDR  in  AW  addresses
- C_WE, Z_WE  in  1  write enable
- C_WDATA, Z_WDATA  in  DW  write data
- C_ACK, Z_ACK  out  1  completions
- RDATA  out  DW  read data, valid with any ACK
- MEM_CMD  out  1  command strobe
- MEM_WE  out  1  write qualifier
- MEM_ADDR  out  AW  address
- MEM_WDATA  out  DW  write data
- MEM_RDATA  in  DW  read return

## Operation
- PHASE increments by 1 every cycle and wraps 7→0. Reset value 3'b100.
- Enables: CE_12M = PHASE[0]; CE_6M = (PHASE[1:0]==2'b11); CE_3M = (PHASE==3'b111).
- Slot owners: phases 0 and 4 → VID; phases 2 and 6 → CPU; phase 7 → Z80; phases 1, 3 and 5 are free.
- Eligible requester: REQ high and busy flag clear.
- Owned slot with an eligible owner → grant to the owner.
- Free slot, or owned slot whose owner is not eligible → grant to VID if eligible. Otherwise grant to CPU or Z80 by round-robin pointer. Otherwise no grant.
- The round-robin pointer toggles only on a free-slot grant to CPU or Z80. Reset value: CPU first.
- A grant sets the requester's busy flag and launches one command on MEM_*.
- Each requester has at most one outstanding command. A shift-register pipeline of RD_LAT stages tracks the owner tag.
- Writes complete like reads. The ACK fires RD_LAT cycles after MEM_CMD, and RDATA is don't-care for writes.
- The busy flag clears at the edge ending the cycle after its ACK. Consequence: REQ still high at the ACK edge is never reissued.
- Requesters hold REQ/ADDR/WE/WDATA stable until ACK. They drop REQ at the edge after ACK unless they want a new access.

## Timing
- Arbitration uses PHASE p and the REQ levels sampled at the edge ending phase p. MEM_CMD, MEM_ADDR, MEM_WE and MEM_WDATA are registered and appear during phase p+1.
- ACK is high in cycle (MEM_CMD cycle + RD_LAT) for exactly 1 cycle. RDATA = MEM_RDATA combinationally in that cycle.
- Only one ACK can be high per cycle, because commands are issued at most one per cycle.
- Reset values: PHASE=4, CE_*=0 (derived from PHASE=4), MEM_CMD=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, all ACK=0, busy flags and pipeline cleared.
- Reset asserted mid-access: the in-flight command is dropped and no ACK is ever generated for it. Requesters restart after release.
- Simultaneous events: a VID and CPU request in the same free slot → VID wins. An owner request and a free-slot contender on an owned phase → the owner wins.
- Worst-case VID wait is 4 cycles; CPU wait is 4 cycles; Z80 wait is 8 cycles.

## Test plan
- Release reset, no requests → PHASE runs 4,5,6,7,0,…; CE_3M high only at PHASE=7; CE_6M at 3 and 7; CE_12M at 1,3,5,7. MEM_CMD stays 0.
- C_REQ=1, C_ADDR=24'h000100, C_WE=0 raised so it is sampled at phase 2 → MEM_CMD with address 000100 during phase 3. With MEM_RDATA=16'hBEEF at +2 cycles → C_ACK=1 and RDATA=BEEF, one cycle.
- V_REQ and C_REQ both eligible at phase 1 → VID is granted. CPU is granted at the next free or owned-CPU slot (phase 2).
- C_REQ and Z_REQ held continuously, VID idle → free slots alternate CPU, Z80, CPU. Z80 also gets phase 7 and CPU gets phases 2 and 6. No requester is ever issued twice while busy.
- Z80 write Z_WE=1, Z_WDATA=16'h1234 → MEM_WE=1 and MEM_WDATA=1234 with MEM_CMD; Z_ACK fires at RD_LAT.
- Pull nRESETP low 1 cycle after a CPU MEM_CMD → no C_ACK is produced and all outputs take their reset values immediately.
